// File: rtl/rat_flag_pkg.sv
// Shared types for the RAT CPU flag unit: the flag pair, the synchronizer depth limits,
// and the carry next-state selection.
package rat_flag_pkg;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    typedef enum logic [2:0] {
        C_HOLD,
        C_LD,
        C_SET,
        C_CLR,
        C_RESTORE
    } c_sel_t;

    // Restore beats clear, clear beats set, set beats load.
    function automatic c_sel_t c_select(input logic ld_sel, input logic clr,
                                        input logic set, input logic ld);
        if (ld_sel)   return C_RESTORE;
        else if (clr) return C_CLR;
        else if (set) return C_SET;
        else if (ld)  return C_LD;
        else          return C_HOLD;
    endfunction

endpackage

// File: rtl/rat_int_sync.sv
// External interrupt synchronizer: a SYNC_STAGES flop chain plus a rising-edge detector
// on the synchronized level.
module rat_int_sync
    import rat_flag_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr,
    output logic sync_level,
    output logic sync_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], intr};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign sync_rise  = sync_level & ~level_d;

endmodule

// File: rtl/rat_flag_unit.sv
// RAT CPU architectural flags: C/Z with shadow copy, interrupt enable I, and the
// pending external interrupt presented to the control unit.
module rat_flag_unit
    import rat_flag_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          INT_EDGE    = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic INTR,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_PEND
);

    flags_t flags_q, flags_d;
    flags_t shadow_q, shadow_d;
    logic   i_q, i_d;
    c_sel_t c_sel;
    logic   sync_level, sync_rise;
    logic   pending;

    rat_int_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (CLK),
        .rst_n     (RST_N),
        .intr      (INTR),
        .sync_level(sync_level),
        .sync_rise (sync_rise)
    );

    always_comb begin
        c_sel   = c_select(FLG_LD_SEL, FLG_C_CLR, FLG_C_SET, FLG_C_LD);
        flags_d = flags_q;
        case (c_sel)
            C_RESTORE: flags_d.c = shadow_q.c;
            C_CLR:     flags_d.c = 1'b0;
            C_SET:     flags_d.c = 1'b1;
            C_LD:      flags_d.c = C_IN;
            default:   flags_d.c = flags_q.c;
        endcase
        if (FLG_LD_SEL)    flags_d.z = shadow_q.z;
        else if (FLG_Z_LD) flags_d.z = Z_IN;

        // Shadow captures pre-edge flags, so restore+save in one cycle swaps them.
        shadow_d = (FLG_SHAD_LD || INT_ACK) ? flags_q : shadow_q;

        i_d = i_q;
        if (INT_ACK)    i_d = 1'b0;
        else if (I_CLR) i_d = 1'b0;
        else if (I_SET) i_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q  <= '0;
            shadow_q <= '0;
            i_q      <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
            i_q      <= i_d;
        end
    end

    generate
        if (INT_EDGE) begin : g_edge
            logic pend_q;
            // A new edge in the acknowledge cycle keeps pending set so it is not lost.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N)        pend_q <= 1'b0;
                else if (sync_rise) pend_q <= 1'b1;
                else if (INT_ACK)   pend_q <= 1'b0;
            end
            assign pending = pend_q;
        end else begin : g_level
            assign pending = sync_level;
        end
    endgenerate

    assign C_FLAG   = flags_q.c;
    assign Z_FLAG   = flags_q.z;
    assign I_FLAG   = i_q;
    assign INT_PEND = pending & i_q;

endmodule
